// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, instruction field
// positions, FSM states and default widths.
package alu_pkg;

    localparam int unsigned ALU_DW    = 8;
    localparam int unsigned ALU_NREGS = 8;
    localparam int unsigned ALU_RW    = 3;
    localparam int unsigned ALU_IW    = 16;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_OR  = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_SLT = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LI  = 4'hF;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_MSB = 8;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_MSB = 5;
    localparam int unsigned RS2_LSB = 3;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, a debug read port and one
// synchronous write port. Entry 0 is hardwired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned NREGS = ALU_NREGS,
    parameter int unsigned DW    = ALU_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [$clog2(NREGS)-1:0] i_raddr1,
    output logic [DW-1:0]            o_rdata1_c,
    input  logic [$clog2(NREGS)-1:0] i_raddr2,
    output logic [DW-1:0]            o_rdata2_c,
    input  logic [$clog2(NREGS)-1:0] i_dbg_addr,
    output logic [DW-1:0]            o_dbg_data_c
);

    logic [DW-1:0] r_mem [NREGS];

    // Writes to r0 are dropped so the zero register stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1_c   = (i_raddr1   == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2_c   = (i_raddr2   == '0) ? '0 : r_mem[i_raddr2];
    assign o_dbg_data_c = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Single-issue operand/writeback stage around an external combinational ALU.
// One instruction in flight: accept -> execute one cycle -> hold result.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned NREGS = ALU_NREGS,
    parameter int unsigned DW    = ALU_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ALU_IW-1:0]        in_instr,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [3:0]               alu_op,
    input  logic [DW-1:0]            alu_res,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DW-1:0]            res_data,
    output logic [$clog2(NREGS)-1:0] res_rd,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DW-1:0]            dbg_data
);

    localparam int unsigned RW = $clog2(NREGS);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_wb;

    logic           r_in_ready;
    logic           r_res_valid;
    logic [3:0]     r_op;
    logic [RW-1:0]  r_rd;
    logic [DW-1:0]  r_imm;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;
    logic [3:0]     r_alu_op;
    logic [DW-1:0]  r_res_data;
    logic [RW-1:0]  r_res_rd;

    logic [3:0]     w_op;
    logic [RW-1:0]  w_rd;
    logic [RW-1:0]  w_rs1;
    logic [RW-1:0]  w_rs2;
    logic [DW-1:0]  w_imm;
    logic [DW-1:0]  w_rdata1;
    logic [DW-1:0]  w_rdata2;
    logic [DW-1:0]  w_wb_data;

    assign w_op  = in_instr[OP_MSB:OP_LSB];
    assign w_rd  = RW'(in_instr[RD_MSB:RD_LSB]);
    assign w_rs1 = RW'(in_instr[RS1_MSB:RS1_LSB]);
    assign w_rs2 = RW'(in_instr[RS2_MSB:RS2_LSB]);
    assign w_imm = DW'(in_instr[IMM_MSB:IMM_LSB]);

    // LI bypasses the ALU and writes its immediate directly.
    assign w_wb_data = (r_op == OP_LI) ? r_imm : alu_res;

    alu_regfile #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regfile (
        .clk          (clk),
        .rst          (rst),
        .i_we         (w_wb),
        .i_waddr      (r_rd),
        .i_wdata      (w_wb_data),
        .i_raddr1     (w_rs1),
        .o_rdata1_c   (w_rdata1),
        .i_raddr2     (w_rs2),
        .o_rdata2_c   (w_rdata2),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_data_c (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wb        = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_wb        = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_res_valid <= (w_state_nxt == DONE);
        end
    end

    // Operands are captured at acceptance and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_accept) begin
            r_op  <= w_op;
            r_rd  <= w_rd;
            r_imm <= w_imm;
            if (w_op == OP_LI) begin
                r_alu_a  <= w_imm;
                r_alu_b  <= '0;
                r_alu_op <= OP_ADD;
            end else begin
                r_alu_a  <= w_rdata1;
                r_alu_b  <= w_rdata2;
                r_alu_op <= w_op;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data <= '0;
            r_res_rd   <= '0;
        end else if (w_wb) begin
            r_res_data <= w_wb_data;
            r_res_rd   <= r_rd;
        end
    end

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_rd    = r_res_rd;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;

endmodule
